rx_queue: RTL and testbench
===========================

Name: rx_queue

Overview:
- Receive-side FIFO directly downstream of the SPI receiver front end.
- Captures each conditioned word on the receiver's single-cycle write strobe (positive-edge alert).
- Buffers up to DEPTH words and presents them to the node logic over a valid/ready handshake.
- Reports occupancy and drops new words on overflow, recording the loss in a sticky flag.

Parameters:
- width, 32: data word width; matches the receiver output width.
- depth, 8: number of entries; power of two, minimum 2.
- cnt_w, $clog2(depth)+1: width of the occupancy count, so it can represent 0..depth.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_data  input  width  conditioned word from the receiver (processed_sig).
- wr_en  input  1  write strobe from the receiver (sig_alert); one word per high cycle.
- out_data  output  width  head-of-queue word.
- out_valid  output  1  queue non-empty; out_data holds the head word.
- out_ready  input  1  consumer accepts the head word this cycle.
- count  output  cnt_w  current number of entries.
- full  output  1  count == depth.
- empty  output  1  count == 0.
- overflow  output  1  sticky; a word was dropped.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync-safe deassert to internal logic):
  - count=0, empty=1, full=0, out_valid=0, overflow=0.
  - Read and write pointers = 0; out_data = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all queued words immediately.
- Storage: circular buffer, depth entries.
  - Read and write pointers are $clog2(depth) bits and wrap naturally from depth-1 to 0.
- First-word fall-through:
  - out_data = mem[rd_ptr], driven combinationally from the registered rd_ptr.
  - out_valid = !empty.
  - A word written at edge N is visible on out_data with out_valid=1 after edge N (latency 1 clk).
- Read fire = out_valid && out_ready. On fire, rd_ptr advances at the edge.
  - out_ready while empty has no effect.
- Write accept = wr_en && (!full || read fire). On accept: mem[wr_ptr] <= wr_data, wr_ptr advances.
- Simultaneous read and write:
  - Not full: both occur; count is unchanged.
  - Full: both occur; the freed slot is reused, count stays at depth, full stays 1, overflow is not set.
  - Empty: no read (out_valid=0); the write occurs; count becomes 1.
- Overflow: wr_en while full and no read fire.
  - The word is dropped; pointers and count are unchanged; overflow <= 1.
- overflow clears only on clr_ovf=1 at a clock edge.
  - If clr_ovf and a new drop coincide, set wins (overflow stays 1).
- count: +1 on write only, -1 on read only, unchanged on both or neither. Never exceeds depth and never underflows.
- full and empty are registered alongside count, with no combinational path from wr_en or out_ready.
- Back-to-back writes on consecutive cycles must be accepted at one per cycle.
  - This is beyond the receiver's strobe rate; the queue does not rely on strobe spacing.

Optional Feature:
- Macro RX_QUEUE_ALMOST_FULL_EN.
- Defined:
  - Adds parameter af_level (default depth-2).
  - Adds output almost_full (1 bit, registered), 1 when the next-state count >= af_level; reset value 0.
  - Upstream uses it for flow-control back-pressure.
- Undefined: no af_level parameter and no almost_full port. All other behaviour is identical.

Decomposition:
- Shared package rx_pkg holds:
  - Default constants RX_WIDTH=32 and RX_DEPTH=8.
  - A function computing cnt_w from depth.
  - Used by rx_queue and the receiver wrapper so the widths stay consistent.
- One natural sub-module: rx_queue_mem.
  - Single-write-port register array with async read, parameterised width/depth.
  - Holds only storage; pointer, count and flag logic stay in rx_queue.

Test Plan:
- Reset/basic: rst_n low, then write 0xDEADBEEF once.
  - Next cycle: out_valid=1, out_data=0xDEADBEEF, count=1, empty=0.
  - out_ready=1 for one cycle: empty=1, count=0.
- Fill/overflow: 8 writes 0x1..0x8 with out_ready=0, then a 9th write 0x9.
  - full=1, count=8, overflow=1.
  - Draining yields exactly 0x1..0x8 in order; 0x9 is never seen.
- Full with simultaneous read/write: at count=8, wr_en=1 with 0xA and out_ready=1 in the same cycle.
  - count stays 8, overflow stays 0.
  - Drain order ends with 0xA.
- Wrap-around: 20 words with continuous interleaved write/read (one in flight).
  - All 20 words are received in order; pointers wrap at least twice.
- Reset mid-operation and flag clear: with count=5, pulse rst_n low asynchronously (off clock edge).
  - Immediately: out_valid=0, count=0.
  - Separately: with overflow=1, clr_ovf for one cycle clears it; clr_ovf coinciding with a drop leaves it at 1.
- RX_QUEUE_ALMOST_FULL_EN with af_level=6:
  - almost_full rises on the edge that makes count 6.
  - It falls on the edge that brings count to 5.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared constants and helpers for the SPI receive path (receiver wrapper and rx_queue).
package rx_pkg;

    localparam int RX_WIDTH = 32;
    localparam int RX_DEPTH = 8;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } rx_op_e;

    // Occupancy counter width: must hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rx_queue_mem.sv
// Storage array for rx_queue: one synchronous write port, asynchronous read port.
module rx_queue_mem #(
    parameter int width = 32,
    parameter int depth = 8,
    parameter int aw    = $clog2(depth)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [aw-1:0]    waddr,
    input  logic [width-1:0] wdata,
    input  logic [aw-1:0]    raddr,
    output logic [width-1:0] rdata
);

    logic [width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rx_queue.sv
// Receive FIFO with first-word fall-through and sticky overflow.
// Optional almost_full output enabled by defining RX_QUEUE_ALMOST_FULL_EN.
module rx_queue
    import rx_pkg::*;
#(
    parameter int width = RX_WIDTH,
    parameter int depth = RX_DEPTH,
    parameter int cnt_w = cnt_width(depth)
`ifdef RX_QUEUE_ALMOST_FULL_EN
    ,
    parameter int af_level = depth - 2
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] wr_data,
    input  logic             wr_en,
    output logic [width-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [cnt_w-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
`ifdef RX_QUEUE_ALMOST_FULL_EN
    output logic             almost_full,
`endif
    input  logic             clr_ovf
);

    localparam int aw = $clog2(depth);

    logic [aw-1:0]    wr_ptr, rd_ptr;
    logic [width-1:0] rd_word;
    logic             fire, accept, drop;
    rx_op_e           op;
    logic [cnt_w-1:0] count_nxt;

    assign fire   = out_valid && out_ready;
    assign accept = wr_en && (!full || fire);
    assign drop   = wr_en && full && !fire;
    assign op     = rx_op_e'({accept, fire});

    always_comb begin
        count_nxt = count;
        unique case (op)
            OP_WRITE: count_nxt = count + cnt_w'(1);
            OP_READ:  count_nxt = count - cnt_w'(1);
            default:  count_nxt = count;
        endcase
    end

    rx_queue_mem #(
        .width (width),
        .depth (depth)
    ) u_mem (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    // Gate with the registered empty flag so out_data reads 0 after reset
    // even though the storage array itself is never cleared.
    assign out_data  = empty ? '0 : rd_word;
    assign out_valid = !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (accept) wr_ptr <= wr_ptr + aw'(1);
            if (fire)   rd_ptr <= rd_ptr + aw'(1);
            count <= count_nxt;
            full  <= (count_nxt == cnt_w'(depth));
            empty <= (count_nxt == '0);
        end
    end

    // Set has priority over clear so a drop in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (clr_ovf) overflow <= 1'b0;
    end

`ifdef RX_QUEUE_ALMOST_FULL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) almost_full <= 1'b0;
        else        almost_full <= (count_nxt >= cnt_w'(af_level));
    end
`endif

endmodule

// File: tb/tb_rx_queue.sv
// Self-checking bench for rx_queue against a queue-based reference model.
module tb_rx_queue;

    localparam int W     = 32;
    localparam int D     = 8;
    localparam int CW    = $clog2(D) + 1;
    localparam int AF    = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          wr_en = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] count;
    logic          full, empty, overflow;
    logic          clr_ovf = 1'b0;
`ifdef RX_QUEUE_ALMOST_FULL_EN
    logic          almost_full;
`endif

    rx_queue #(
        .width (W),
        .depth (D)
`ifdef RX_QUEUE_ALMOST_FULL_EN
        ,
        .af_level (AF)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
`ifdef RX_QUEUE_ALMOST_FULL_EN
        .almost_full (almost_full),
`endif
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    int unsigned   n_pass = 0;
    int unsigned   n_total = 0;
    logic [W-1:0]  mq[$];
    logic          m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_all(input string ctx);
        chk({ctx, ".count"},     W'(count),     W'(mq.size()));
        chk({ctx, ".empty"},     W'(empty),     W'(mq.size() == 0));
        chk({ctx, ".full"},      W'(full),      W'(mq.size() == D));
        chk({ctx, ".out_valid"}, W'(out_valid), W'(mq.size() != 0));
        chk({ctx, ".out_data"},  out_data,      (mq.size() != 0) ? mq[0] : '0);
        chk({ctx, ".overflow"},  W'(overflow),  W'(m_ovf));
`ifdef RX_QUEUE_ALMOST_FULL_EN
        chk({ctx, ".almost_full"}, W'(almost_full), W'(mq.size() >= AF));
`endif
    endtask

    // Drive one cycle of inputs, let the edge happen, update the model, compare.
    task automatic step(input string ctx, input logic w, input logic [W-1:0] d,
                        input logic r, input logic c);
        int  n;
        bit  fire, acc;
        wr_en = w; wr_data = d; out_ready = r; clr_ovf = c;
        @(posedge clk);
        n    = mq.size();
        fire = (n > 0) && r;
        acc  = w && ((n < D) || fire);
        if (fire) void'(mq.pop_front());
        if (acc)  mq.push_back(d);
        if (w && (n == D) && !fire) m_ovf = 1'b1;
        else if (c)                 m_ovf = 1'b0;
        #1;
        chk_all(ctx);
    endtask

    task automatic idle();
        wr_en = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("reset.count",     W'(count),     '0);
        chk("reset.empty",     W'(empty),     W'(1));
        chk("reset.full",      W'(full),      '0);
        chk("reset.out_valid", W'(out_valid), '0);
        chk("reset.overflow",  W'(overflow),  '0);
        chk("reset.out_data",  out_data,      '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic write then read
        step("basic_wr", 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        step("basic_rd", 1'b0, '0, 1'b1, 1'b0);
        step("rd_empty", 1'b0, '0, 1'b1, 1'b0);

        // Fill, overflow, drain
        for (int unsigned i = 1; i <= 8; i++) step("fill", 1'b1, W'(i), 1'b0, 1'b0);
        step("ovf_drop", 1'b1, 32'h9, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 9; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);

        // Clear overflow, refill, simultaneous read/write while full
        step("clr_ovf", 1'b0, '0, 1'b0, 1'b1);
        for (int unsigned i = 1; i <= 8; i++) step("fill2", 1'b1, W'(32'h10 + i), 1'b0, 1'b0);
        step("full_rw", 1'b1, 32'hA, 1'b1, 1'b0);
        step("clr_and_drop", 1'b1, 32'hBAD, 1'b0, 1'b1);
        step("clr_after", 1'b0, '0, 1'b0, 1'b1);
        for (int unsigned i = 0; i < 9; i++) step("drain2", 1'b0, '0, 1'b1, 1'b0);

        // Wrap-around: continuous interleaved write/read
        step("wrap_first", 1'b1, 32'h100, 1'b0, 1'b0);
        for (int unsigned i = 1; i < 20; i++) step("wrap", 1'b1, W'(32'h100 + i), 1'b1, 1'b0);
        step("wrap_last", 1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic
        for (int unsigned i = 0; i < 400; i++)
            step("rand", 1'($urandom_range(0, 99) < 60), $urandom, 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 99) < 5));

        // Async reset mid-operation with count=5
        while (mq.size() > 0) step("pre_rst_drain", 1'b0, '0, 1'b1, 1'b0);
        for (int unsigned i = 0; i < 5; i++) step("pre_rst_fill", 1'b1, W'(32'h200 + i), 1'b0, 1'b0);
        idle();
        #3 rst_n = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        chk("async_rst.out_valid", W'(out_valid), '0);
        chk("async_rst.count",     W'(count),     '0);
        chk("async_rst.out_data",  out_data,      '0);
        #2 rst_n = 1'b1;
        step("post_rst", 1'b1, 32'h300, 1'b0, 1'b0);
        step("post_rst_rd", 1'b0, '0, 1'b1, 1'b0);

        idle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL timeout: bench did not finish within time limit");
    end

endmodule
